a23_run_ctrl: RTL
=================

A23_RUN_CTRL -- requirements
Module: a23_run_ctrl

Interface
REQ-001 Parameter OUT_MEM_SIZE, default 64, number of 32-bit output words produced by the core.
REQ-002 Parameter RST_CYCLES, default 3, number of cycles core_rst is held high before a run starts (minimum 1).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request.
REQ-006 abort  input  1  cancels an in-progress run.
REQ-007 max_cycles  input  32  cycle budget for a run; 0 means unlimited; sampled on accepted start.
REQ-008 core_rst  output  1  reset driven to the garbled-circuit processor core.
REQ-009 core_terminate  input  1  terminate flag from the core.
REQ-010 core_o  input  OUT_MEM_SIZE*32  core output memory; word i occupies bits [32*i+31:32*i].
REQ-011 busy  output  1  high in RESET, RUN and DRAIN.
REQ-012 done  output  1  high in DONE.
REQ-013 timeout  output  1  run ended by the cycle budget.
REQ-014 cycle_count  output  32  number of run cycles counted.
REQ-015 rd_valid, rd_ready, rd_data[31:0], rd_last  out/in/out/out  word-serial readout stream.

Function
REQ-016 The block SHALL implement the states IDLE, RESET, RUN, DRAIN and DONE.
REQ-017 IDLE and DONE: core_rst=1, rd_valid=0; start=1 SHALL move to RESET and clear cycle_count, timeout and done, and latch max_cycles.
REQ-018 start SHALL be ignored in RESET, RUN and DRAIN.
REQ-019 RESET: core_rst=1 for exactly RST_CYCLES cycles via a down-counter, then SHALL enter RUN.
REQ-020 RUN: core_rst=0; each cycle with core_terminate=0, cycle_count SHALL increment by 1, saturating at 0xFFFFFFFF.
REQ-021 RUN with core_terminate=1: no increment; core_o SHALL be captured into a snapshot register, with the move to DRAIN in the same edge.
REQ-022 RUN with core_terminate=0 and latched budget nonzero and cycle_count==budget: timeout SHALL be set, core_o captured, and the state SHALL move to DRAIN; at most budget cycles are counted.
REQ-023 terminate and budget exhaustion in the same cycle: terminate SHALL win and timeout stays 0.
REQ-024 DRAIN: core_rst=1; rd_valid=1; rd_data=snapshot word k, with k starting at 0; rd_last=1 when k==OUT_MEM_SIZE-1.
REQ-025 k SHALL advance only on rd_valid&rd_ready, and rd_data SHALL stay stable while rd_ready=0.
REQ-026 acceptance of the last word SHALL move the state to DONE, with done=1 from the next cycle.
REQ-027 the snapshot SHALL be unaffected by core_o changes after capture.
REQ-028 abort=1 in RESET/RUN/DRAIN SHALL return to IDLE next cycle: core_rst=1, rd_valid=0, busy=0, done=0; cycle_count is retained.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 abort and start in the same cycle in IDLE/DONE: start SHALL win.
REQ-031 cycle_count and timeout SHALL hold their values in DONE until the next accepted start.

Reset
REQ-032 rst=1 SHALL force IDLE from any state on the next edge, overriding start and abort.
REQ-033 rst=1 SHALL set core_rst=1, busy=0, done=0, timeout=0, cycle_count=0, rd_valid=0, rd_last=0, rd_data=0, k=0 and the snapshot to 0.
REQ-034 rst SHALL take priority over all other inputs, including mid-run and mid-drain.

Verification
REQ-035 RST_CYCLES=3, max_cycles=0, start pulse, core_terminate raised on the 10th RUN cycle -> core_rst high for 3 cycles; cycle_count=9; timeout=0; DRAIN entered.
REQ-036 core_o word i = 0x1000+i, rd_ready=1 -> 64 consecutive words 0x1000..0x103F; rd_last only on 0x103F; done=1 the cycle after.
REQ-037 max_cycles=5, terminate never asserted -> cycle_count=5, timeout=1, snapshot drained; core_o changed during drain does not alter rd_data.
REQ-038 max_cycles=5, terminate asserted exactly when cycle_count==5 -> timeout=0, cycle_count=5.
REQ-039 rd_ready toggled 1,0,0,1 per cycle during DRAIN -> each word is held while rd_ready=0; no word is skipped or duplicated.
REQ-040 abort during RUN, then rst asserted during a later DRAIN, then start -> each event returns to IDLE with the values in REQ-028/REQ-033; a fresh run after start completes normally.

Source files
------------

// File: rtl/a23_run_ctrl.sv
// a23_run_ctrl: run controller for a garbled-circuit processor core.
// Holds the core in reset, lets it run under an optional cycle budget,
// snapshots its output memory when the run ends, then streams the snapshot
// out one 32-bit word at a time over a valid/ready handshake.
module a23_run_ctrl #(
    parameter int OUT_MEM_SIZE = 64,
    parameter int RST_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               max_cycles,
    output logic                      core_rst,
    input  logic                      core_terminate,
    input  logic [OUT_MEM_SIZE*32-1:0] core_o,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [31:0]               cycle_count,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [31:0]               rd_data,
    output logic                      rd_last
);

    localparam int MW = OUT_MEM_SIZE * 32;
    localparam int KW = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
    // The reset down-counter only ever holds values 0 .. RST_CYCLES-1.
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(OUT_MEM_SIZE - 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Pick 32-bit word idx out of a packed output-memory image.
    function automatic logic [31:0] sel_word(input logic [MW-1:0] mem,
                                             input logic [KW-1:0] idx);
        logic [31:0] w;
        w = 32'h0000_0000;
        for (int i = 0; i < OUT_MEM_SIZE; i++) begin
            if (idx == KW'(i)) begin
                w = mem[32*i +: 32];
            end
        end
        return w;
    endfunction

    // Control state
    state_t          state_q,       state_d;
    logic [RW-1:0]   rst_cnt_q,     rst_cnt_d;
    logic [KW-1:0]   k_q,           k_d;
    logic [31:0]     budget_q,      budget_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic            timeout_q,     timeout_d;
    logic [MW-1:0]   snap_q,        snap_d;

    // Registered outputs, decoded from the next state
    logic            core_rst_q,    core_rst_d;
    logic            busy_q,        busy_d;
    logic            done_q,        done_d;
    logic            rd_valid_q,    rd_valid_d;
    logic            rd_last_q,     rd_last_d;
    logic [31:0]     rd_data_q,     rd_data_d;

    // Next-state logic: run sequencing, cycle budget, snapshot and readout index.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        k_d           = k_q;
        budget_d      = budget_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        snap_d        = snap_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort is meaningless here; start always wins
                if (start) begin
                    state_d       = ST_RESET;
                    rst_cnt_d     = RST_LOAD;
                    k_d           = {KW{1'b0}};
                    budget_d      = max_cycles;
                    cycle_count_d = 32'h0000_0000;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_RESET: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rst_cnt_q == {RW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (core_terminate) begin
                    // terminate beats budget exhaustion in the same cycle
                    snap_d  = core_o;
                    k_d     = {KW{1'b0}};
                    state_d = ST_DRAIN;
                end else if ((budget_q != 32'h0000_0000) && (cycle_count_q == budget_q)) begin
                    timeout_d = 1'b1;
                    snap_d    = core_o;
                    k_d       = {KW{1'b0}};
                    state_d   = ST_DRAIN;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end else begin
                    cycle_count_d = cycle_count_q;
                end
            end

            ST_DRAIN: begin
                // rd_valid is high throughout DRAIN, so rd_ready alone is the handshake
                if (abort) begin
                    state_d = ST_IDLE;
                    k_d     = {KW{1'b0}};
                end else if (rd_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                        k_d     = {KW{1'b0}};
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        core_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        rd_valid_d = (state_d == ST_DRAIN);
        if (state_d == ST_DRAIN) begin
            rd_last_d = (k_d == K_LAST);
            rd_data_d = sel_word(snap_d, k_d);
        end else begin
            rd_last_d = 1'b0;
            rd_data_d = 32'h0000_0000;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= {RW{1'b0}};
            k_q           <= {KW{1'b0}};
            budget_q      <= 32'h0000_0000;
            cycle_count_q <= 32'h0000_0000;
            timeout_q     <= 1'b0;
            snap_q        <= {MW{1'b0}};
            core_rst_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_data_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            k_q           <= k_d;
            budget_q      <= budget_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            snap_q        <= snap_d;
            core_rst_q    <= core_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_data     = rd_data_q;

endmodule
